// File: rtl/maze_renderer.sv
// Maze engine for the VGA path. It holds a writable ROWS x COLS wall bitmap
// and the player's cell, and applies single-step moves with wall and bound
// checks. It raises a sticky 'won' flag when the player reaches the goal
// cell, and renders the grid, player and goal into a registered rgb stream
// with a two-cycle latency.
// Ports:
//   clk, reset          pixel clock, synchronous active-high reset
//   bright              visible-area flag from the sync generator
//   hCount, vCount      current pixel coordinates
//   wr_en/wr_row/wr_data  write one maze row (bit c = column c, 1 = wall)
//   mv_up/down/left/right single-cycle move requests
//   rgb                 registered 12-bit pixel colour
//   player_row/col      current player cell
//   won                 player has reached the goal (sticky until reset)
module maze_renderer #(
  parameter int unsigned ROWS       = 15,
  parameter int unsigned COLS       = 15,
  parameter int unsigned CELL_SHIFT = 4,
  parameter int unsigned X0         = 344,
  parameter int unsigned Y0         = 155,
  parameter int unsigned START_ROW  = 0,
  parameter int unsigned START_COL  = 0,
  parameter int unsigned GOAL_ROW   = ROWS - 1,
  parameter int unsigned GOAL_COL   = COLS - 1,
  parameter logic [11:0] BG_RGB     = 12'hFFF,
  parameter logic [11:0] WALL_RGB   = 12'h000,
  parameter logic [11:0] PATH_RGB   = 12'hCCC,
  parameter logic [11:0] PLAYER_RGB = 12'hF00,
  parameter logic [11:0] GOAL_RGB   = 12'h0F0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bright,
  input  logic [9:0]       hCount,
  input  logic [9:0]       vCount,
  input  logic             wr_en,
  input  logic [3:0]       wr_row,
  input  logic [COLS-1:0]  wr_data,
  input  logic             mv_up,
  input  logic             mv_down,
  input  logic             mv_left,
  input  logic             mv_right,
  output logic [11:0]      rgb,
  output logic [3:0]       player_row,
  output logic [3:0]       player_col,
  output logic             won
);

  localparam int unsigned X_END = X0 + (COLS << CELL_SHIFT);
  localparam int unsigned Y_END = Y0 + (ROWS << CELL_SHIFT);

  typedef enum logic {S_PLAY = 1'b0, S_WON = 1'b1} state_e;

  // Maze is always stored as 16x16; rows/cols beyond ROWS/COLS are never
  // written, so they stay 0 and fall away in synthesis.
  logic [15:0][15:0] maze_q, maze_d;
  logic [3:0]        player_row_q, player_row_d;
  logic [3:0]        player_col_q, player_col_d;
  state_e            state_q, state_d;
  logic              pipe_valid_q, pipe_valid_d;
  logic              bright_s1_q, bright_s1_d;
  logic              inside_s1_q, inside_s1_d;
  logic [3:0]        row_s1_q, row_s1_d;
  logic [3:0]        col_s1_q, col_s1_d;
  logic [11:0]       rgb_q, rgb_d;

  logic [3:0] cand_row, cand_col;
  logic [2:0] n_req;
  logic       in_bounds;
  logic       accept;

  // Maze row write; out-of-range rows are dropped.
  always_comb begin
    maze_d = maze_q;
    if (wr_en && (32'(wr_row) < ROWS)) begin
      maze_d[wr_row] = 16'(wr_data);
    end
  end

  // Move candidate, bound check and wall check against pre-write contents.
  always_comb begin
    cand_row  = player_row_q;
    cand_col  = player_col_q;
    in_bounds = 1'b0;
    n_req     = 3'(mv_up) + 3'(mv_down) + 3'(mv_left) + 3'(mv_right);
    if (mv_up) begin
      cand_row  = player_row_q - 4'd1;
      in_bounds = (player_row_q != 4'd0);
    end else if (mv_down) begin
      cand_row  = player_row_q + 4'd1;
      in_bounds = ((32'(player_row_q) + 32'd1) < ROWS);
    end else if (mv_left) begin
      cand_col  = player_col_q - 4'd1;
      in_bounds = (player_col_q != 4'd0);
    end else if (mv_right) begin
      cand_col  = player_col_q + 4'd1;
      in_bounds = ((32'(player_col_q) + 32'd1) < COLS);
    end
    accept = (n_req == 3'd1) && in_bounds && (state_q == S_PLAY) &&
             !maze_q[cand_row][cand_col];
    player_row_d = accept ? cand_row : player_row_q;
    player_col_d = accept ? cand_col : player_col_q;
  end

  // Win FSM: next state.
  always_comb begin
    state_d = state_q;
    if ((state_q == S_PLAY) &&
        (player_row_d == 4'(GOAL_ROW)) && (player_col_d == 4'(GOAL_COL))) begin
      state_d = S_WON;
    end
  end

  // Win FSM: output decode.
  always_comb begin
    won = 1'b0;
    if (state_q == S_WON) begin
      won = 1'b1;
    end
  end

  // Pixel stage 1: grid hit test and cell coordinates.
  // pipe_valid_q keeps the first post-reset pixel dark so rgb stays 0 for
  // the reset edge plus two more edges.
  always_comb begin
    pipe_valid_d = 1'b1;
    bright_s1_d  = bright & pipe_valid_q;
    inside_s1_d  = (32'(hCount) >= X0) && (32'(hCount) < X_END) &&
                   (32'(vCount) >= Y0) && (32'(vCount) < Y_END);
    row_s1_d     = 4'd0;
    col_s1_d     = 4'd0;
    if (inside_s1_d) begin
      row_s1_d = 4'((vCount - 10'(Y0)) >> CELL_SHIFT);
      col_s1_d = 4'((hCount - 10'(X0)) >> CELL_SHIFT);
    end
  end

  // Pixel stage 2: priority colour selection using current maze/player.
  always_comb begin
    rgb_d = 12'h000;
    if (!bright_s1_q) begin
      rgb_d = 12'h000;
    end else if (!inside_s1_q) begin
      rgb_d = BG_RGB;
    end else if ((row_s1_q == player_row_q) && (col_s1_q == player_col_q)) begin
      rgb_d = PLAYER_RGB;
    end else if ((row_s1_q == 4'(GOAL_ROW)) && (col_s1_q == 4'(GOAL_COL))) begin
      rgb_d = GOAL_RGB;
    end else if (maze_q[row_s1_q][col_s1_q]) begin
      rgb_d = WALL_RGB;
    end else begin
      rgb_d = PATH_RGB;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      maze_q       <= '0;
      player_row_q <= 4'(START_ROW);
      player_col_q <= 4'(START_COL);
      state_q      <= S_PLAY;
      pipe_valid_q <= 1'b0;
      bright_s1_q  <= 1'b0;
      inside_s1_q  <= 1'b0;
      row_s1_q     <= 4'd0;
      col_s1_q     <= 4'd0;
      rgb_q        <= 12'h000;
    end else begin
      maze_q       <= maze_d;
      player_row_q <= player_row_d;
      player_col_q <= player_col_d;
      state_q      <= state_d;
      pipe_valid_q <= pipe_valid_d;
      bright_s1_q  <= bright_s1_d;
      inside_s1_q  <= inside_s1_d;
      row_s1_q     <= row_s1_d;
      col_s1_q     <= col_s1_d;
      rgb_q        <= rgb_d;
    end
  end

  assign rgb        = rgb_q;
  assign player_row = player_row_q;
  assign player_col = player_col_q;

endmodule

// File: tb/tb_maze_renderer.sv
// Bench for maze_renderer: directed test-plan sequence with literal
// expectations, then randomized traffic, all checked every cycle against a
// behavioural model of the maze game and the renderer.
module tb_maze_renderer;

  localparam int ROWS = 15;
  localparam int COLS = 15;
  localparam int X0   = 344;
  localparam int Y0   = 155;
  localparam int CELL = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            bright = 1'b0;
  logic [9:0]      hCount = '0;
  logic [9:0]      vCount = '0;
  logic            wr_en = 1'b0;
  logic [3:0]      wr_row = '0;
  logic [COLS-1:0] wr_data = '0;
  logic            mv_up = 1'b0, mv_down = 1'b0, mv_left = 1'b0, mv_right = 1'b0;
  logic [11:0]     rgb;
  logic [3:0]      player_row, player_col;
  logic            won;

  maze_renderer dut (
    .clk(clk), .reset(reset), .bright(bright), .hCount(hCount), .vCount(vCount),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left), .mv_right(mv_right),
    .rgb(rgb), .player_row(player_row), .player_col(player_col), .won(won)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_wall [16][16];
  int m_pr, m_pc;
  bit m_won;
  bit model_ok = 1'b0;
  bit r1 = 1'b0, r2 = 1'b0;
  bit p_b = 1'b0;
  int p_h = 0, p_v = 0;
  int exp_rgb = 0;

  function automatic int render(input bit b, input int h, input int v);
    int r, c;
    if (!b) return 'h000;
    if (h < X0 || h >= X0 + COLS * CELL || v < Y0 || v >= Y0 + ROWS * CELL) return 'hFFF;
    r = (v - Y0) / CELL;
    c = (h - X0) / CELL;
    if (r == m_pr && c == m_pc) return 'hF00;
    if (r == ROWS - 1 && c == COLS - 1) return 'h0F0;
    if (m_wall[r][c]) return 'h000;
    return 'hCCC;
  endfunction

  always @(posedge clk) begin
    int nm, nr, nc;
    // Pixel seen at the previous edge is coloured with the state held now.
    exp_rgb = (reset || r1 || r2) ? 0 : render(p_b, p_h, p_v);
    r2 = r1;
    r1 = reset;
    p_b = bright;
    p_h = int'(hCount);
    p_v = int'(vCount);
    if (reset) begin
      foreach (m_wall[i, j]) m_wall[i][j] = 1'b0;
      m_pr = 0; m_pc = 0; m_won = 1'b0; model_ok = 1'b1;
    end else begin
      nm = int'(mv_up) + int'(mv_down) + int'(mv_left) + int'(mv_right);
      if (!m_won && nm == 1) begin
        nr = m_pr + (mv_down ? 1 : 0) - (mv_up ? 1 : 0);
        nc = m_pc + (mv_right ? 1 : 0) - (mv_left ? 1 : 0);
        if (nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS && !m_wall[nr][nc]) begin
          m_pr = nr; m_pc = nc;
          if (m_pr == ROWS - 1 && m_pc == COLS - 1) m_won = 1'b1;
        end
      end
      if (wr_en && int'(wr_row) < ROWS)
        for (int c = 0; c < COLS; c++) m_wall[wr_row][c] = wr_data[c];
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("rgb", int'(rgb), exp_rgb);
      chk("player_row", int'(player_row), m_pr);
      chk("player_col", int'(player_col), m_pc);
      chk("won", int'(won), int'(m_won));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pix(input int h, input int v, input bit b, input int exp, input string nm);
    @(negedge clk);
    hCount = 10'(h); vCount = 10'(v); bright = b;
    @(negedge clk);
    @(negedge clk);
    chk(nm, int'(rgb), exp);
  endtask

  task automatic do_move(input bit u, input bit d, input bit l, input bit r);
    @(negedge clk);
    mv_up = u; mv_down = d; mv_left = l; mv_right = r;
    @(negedge clk);
    mv_up = 1'b0; mv_down = 1'b0; mv_left = 1'b0; mv_right = 1'b0;
  endtask

  task automatic wr(input int row, input logic [COLS-1:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_row = 4'(row); wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int sel;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_player_row", int'(player_row), 0);
    chk("reset_player_col", int'(player_col), 0);
    chk("reset_won", int'(won), 0);

    // Frame landmarks after reset.
    pix(X0, Y0, 1'b1, 'hF00, "px_player_cell");
    pix(X0 + 224, Y0 + 224, 1'b1, 'h0F0, "px_goal_cell");
    pix(X0 + 16, Y0, 1'b1, 'hCCC, "px_path_cell");
    pix(X0 - 1, Y0, 1'b1, 'hFFF, "px_left_of_grid");
    pix(X0 + 240, Y0, 1'b1, 'hFFF, "px_right_of_grid");
    pix(X0 + 239, Y0 + 239, 1'b1, 'h0F0, "px_last_grid_pixel");
    pix(X0, Y0, 1'b0, 'h000, "px_blank");

    // Wall to the right blocks the move; moving down is open.
    wr(0, 15'h0002);
    do_move(0, 0, 0, 1);
    chk("blocked_right_col", int'(player_col), 0);
    do_move(0, 1, 0, 0);
    chk("down_row", int'(player_row), 1);
    pix(X0 + 16, Y0, 1'b1, 'h000, "px_wall_cell");

    // Edge and multi-request moves are ignored.
    do_move(1, 0, 0, 0);
    chk("back_up_row", int'(player_row), 0);
    do_move(1, 0, 0, 0);
    do_move(0, 0, 1, 0);
    do_move(1, 0, 0, 1);
    chk("edge_row", int'(player_row), 0);
    chk("edge_col", int'(player_col), 0);

    // Walk to the goal through an open maze.
    pulse_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 14; i++) do_move(0, 1, 0, 0);
    for (int i = 0; i < 13; i++) do_move(0, 0, 0, 1);
    chk("won_before_goal", int'(won), 0);
    do_move(0, 0, 0, 1);
    chk("won_at_goal", int'(won), 1);
    chk("goal_row", int'(player_row), 14);
    chk("goal_col", int'(player_col), 14);
    do_move(1, 0, 0, 0);
    chk("won_locked_row", int'(player_row), 14);

    // Wall written under the player does not displace it.
    wr(14, 15'h4000);
    chk("wall_under_player_row", int'(player_row), 14);
    pix(X0 + 224, Y0 + 224, 1'b1, 'hF00, "px_player_over_wall");
    wr(15, 15'h7FFF);
    pix(X0, Y0 + 224, 1'b1, 'hCCC, "px_row15_write_ignored");

    // Reset in mid-frame.
    wr(0, 15'h0002);
    @(negedge clk);
    hCount = 10'(X0); vCount = 10'(Y0); bright = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_rgb_0", int'(rgb), 0);
    @(negedge clk);
    chk("rst_rgb_1", int'(rgb), 0);
    @(negedge clk);
    chk("rst_rgb_2", int'(rgb), 0);
    @(negedge clk);
    chk("rst_rgb_3", int'(rgb), 'hF00);
    chk("rst_won", int'(won), 0);
    chk("rst_row", int'(player_row), 0);
    pix(X0 + 16, Y0, 1'b1, 'hCCC, "px_maze_cleared");

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      bright = ($urandom % 8) != 0;
      hCount = 10'(X0 - 8 + int'($urandom % 256));
      vCount = 10'(Y0 - 8 + int'($urandom % 256));
      sel = int'($urandom % 8);
      mv_up = (sel == 0) || (sel == 4);
      mv_down = (sel == 1);
      mv_left = (sel == 2) || (sel == 4);
      mv_right = (sel == 3);
      wr_en = ($urandom % 12) == 0;
      wr_row = 4'($urandom % 16);
      wr_data = COLS'($urandom & $urandom & $urandom);
      reset = ($urandom % 400) == 0;
    end
    @(negedge clk);
    reset = 1'b0; wr_en = 1'b0;
    mv_up = 1'b0; mv_down = 1'b0; mv_left = 1'b0; mv_right = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
